// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 16-bit CPU datapath: opcodes, sequencer
// states, bus select codes and ALU operation codes (also used by the ALU).
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_XOR = 3'b011,
      OP_OR  = 3'b100,
      OP_AND = 3'b101,
      OP_NOP = 3'b110,
      OP_ILL = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_A = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } seq_state_t;

   localparam logic [3:0] BUS_SEL_R0   = 4'd0;
   localparam logic [3:0] BUS_SEL_R1   = 4'd1;
   localparam logic [3:0] BUS_SEL_R2   = 4'd2;
   localparam logic [3:0] BUS_SEL_R3   = 4'd3;
   localparam logic [3:0] BUS_SEL_R4   = 4'd4;
   localparam logic [3:0] BUS_SEL_R5   = 4'd5;
   localparam logic [3:0] BUS_SEL_R6   = 4'd6;
   localparam logic [3:0] BUS_SEL_R7   = 4'd7;
   localparam logic [3:0] BUS_SEL_G    = 4'd8;
   localparam logic [3:0] BUS_SEL_IMM  = 4'd9;
   localparam logic [3:0] BUS_SEL_NONE = 4'd15;

   localparam logic [2:0] ALU_OP_PASS = 3'b000;
   localparam logic [2:0] ALU_OP_ADD  = 3'b010;
   localparam logic [2:0] ALU_OP_XOR  = 3'b011;
   localparam logic [2:0] ALU_OP_OR   = 3'b100;
   localparam logic [2:0] ALU_OP_AND  = 3'b101;

   // Two-operand opcodes that need the A register loaded first
   function automatic logic is_alu_op(input opcode_t op);
      return (op == OP_ADD) || (op == OP_XOR) || (op == OP_OR) || (op == OP_AND);
   endfunction

   // ALU select for an opcode; moves use PASS
   function automatic logic [2:0] alu_op_of(input opcode_t op);
      case (op)
         OP_ADD:  return ALU_OP_ADD;
         OP_XOR:  return ALU_OP_XOR;
         OP_OR:   return ALU_OP_OR;
         OP_AND:  return ALU_OP_AND;
         default: return ALU_OP_PASS;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_perf_cnt.sv
// Performance counters for the ALU sequencer: retired instructions and busy
// cycles, both 16-bit and wrapping, cleared by synchronous reset.
module alu_seq_perf_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        done,
   input  logic        busy,
   output logic [15:0] retired_cnt,
   output logic [15:0] busy_cnt
);

   logic [15:0] retired_cnt_reg;
   logic [15:0] busy_cnt_reg;

   // Count done pulses and non-idle cycles; natural 16-bit wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_cnt_reg <= 16'd0;
         busy_cnt_reg    <= 16'd0;
      end else begin
         if (done) retired_cnt_reg <= retired_cnt_reg + 16'd1;
         if (busy) busy_cnt_reg    <= busy_cnt_reg + 16'd1;
      end
   end

   assign retired_cnt = retired_cnt_reg;
   assign busy_cnt    = busy_cnt_reg;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath. Accepts one
// instruction per valid/ready handshake and steps bus select, A/G loads, ALU
// op and register write-back. All outputs are registered (Moore).
// Optional feature macro: ALU_SEQ_PERF_EN adds retired_cnt and busy_cnt ports.
module alu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int IMM_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [15:0]      instr,
   output logic [3:0]       bus_sel,
   output logic [15:0]      imm,
   output logic             a_load,
   output logic             g_load,
   output logic [2:0]       alu_op_select,
   output logic [NREGS-1:0] rf_we,
   output logic             done,
   output logic             illegal
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [15:0]      retired_cnt,
   output logic [15:0]      busy_cnt
`endif
);

   seq_state_t  state_reg;
   logic [15:0] ir_reg;
   logic [3:0]  bus_sel_reg;
   logic        a_load_reg;
   logic        g_load_reg;
   logic [2:0]  alu_op_reg;
   logic        wb_we_reg;
   logic        done_reg;
   logic        illegal_reg;

   opcode_t     in_op;
   opcode_t     ir_op;

   assign in_op = opcode_t'(instr[15:13]);
   assign ir_op = opcode_t'(ir_reg[15:13]);

   // Sequencer FSM; each transition also registers the outputs of the state it enters
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         ir_reg      <= 16'd0;
         bus_sel_reg <= BUS_SEL_NONE;
         a_load_reg  <= 1'b0;
         g_load_reg  <= 1'b0;
         alu_op_reg  <= ALU_OP_PASS;
         wb_we_reg   <= 1'b0;
         done_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         bus_sel_reg <= BUS_SEL_NONE;
         a_load_reg  <= 1'b0;
         g_load_reg  <= 1'b0;
         alu_op_reg  <= ALU_OP_PASS;
         wb_we_reg   <= 1'b0;
         done_reg    <= 1'b0;
         illegal_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (instr_valid) begin
                  ir_reg <= instr;
                  if (is_alu_op(in_op)) begin
                     state_reg   <= ST_LOAD_A;
                     bus_sel_reg <= {1'b0, instr[12:10]};
                     a_load_reg  <= 1'b1;
                  end else if (in_op == OP_MV) begin
                     state_reg   <= ST_EXEC;
                     bus_sel_reg <= {1'b0, instr[9:7]};
                     g_load_reg  <= 1'b1;
                  end else if (in_op == OP_MVI) begin
                     state_reg   <= ST_EXEC;
                     bus_sel_reg <= BUS_SEL_IMM;
                     g_load_reg  <= 1'b1;
                  end else if (in_op == OP_NOP) begin
                     done_reg    <= 1'b1;
                  end else begin
                     illegal_reg <= 1'b1;
                  end
               end
            end
            ST_LOAD_A: begin
               // Only ALU ops pass through here, so ry always drives the bus
               state_reg   <= ST_EXEC;
               bus_sel_reg <= {1'b0, ir_reg[9:7]};
               alu_op_reg  <= alu_op_of(ir_op);
               g_load_reg  <= 1'b1;
            end
            ST_EXEC: begin
               state_reg   <= ST_WB;
               bus_sel_reg <= BUS_SEL_G;
               wb_we_reg   <= 1'b1;
               done_reg    <= 1'b1;
            end
            ST_WB: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // One-hot write enable from the registered rx field
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf_we
      assign rf_we[gi] = wb_we_reg && (ir_reg[12:10] == 3'(gi));
   end

   assign instr_ready   = (state_reg == ST_IDLE);
   assign imm           = {{(16-IMM_W){1'b0}}, ir_reg[IMM_W-1:0]};
   assign bus_sel       = bus_sel_reg;
   assign a_load        = a_load_reg;
   assign g_load        = g_load_reg;
   assign alu_op_select = alu_op_reg;
   assign done          = done_reg;
   assign illegal       = illegal_reg;

`ifdef ALU_SEQ_PERF_EN
   alu_seq_perf_cnt u_perf_cnt (
      .clk         (clk),
      .reset       (reset),
      .done        (done_reg),
      .busy        (state_reg != ST_IDLE),
      .retired_cnt (retired_cnt),
      .busy_cnt    (busy_cnt)
   );
`endif

endmodule
